// File: rtl/conbus_traffic_master_if.sv
// Wishbone master-side bus bundle for the conbus traffic master.
// Signal names follow the master's point of view (_o driven by master, _i driven by slave).
interface conbus_traffic_master_if;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [2:0]  m_cti_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_ack_i;

    modport master (
        output m_adr_o, m_dat_o, m_cti_o, m_we_o, m_sel_o, m_cyc_o, m_stb_o,
        input  m_dat_i, m_ack_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_cti_o, m_we_o, m_sel_o, m_cyc_o, m_stb_o,
        output m_dat_i, m_ack_i
    );
endinterface

// File: rtl/conbus_traffic_master.sv
// LFSR-driven Wishbone write/readback traffic master with data checking and timeouts.
// Define CONBUS_TM_BURST_EN for BURST_LEN-beat incrementing bursts; default is classic single beats.
module conbus_traffic_master #(
    parameter int          ID        = 0,
    parameter int          NSLAVES   = 5,
    parameter int          NTRANS    = 128,
    parameter int          PROB_BITS = 2,
    parameter int          BURST_LEN = 4,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic                           sys_clk_i,
    input  logic                           sys_rst_n_i,
    input  logic                           enable_i,
    conbus_traffic_master_if.master        wb,
    output logic                           done_o,
    output logic [15:0]                    trans_count_o,
    output logic [15:0]                    err_count_o,
    output logic                           timeout_o
);

`ifdef CONBUS_TM_BURST_EN
    localparam bit BURST_SEL = 1'b1;
`else
    localparam bit BURST_SEL = 1'b0;
`endif

    localparam int          NBEATS     = BURST_SEL ? BURST_LEN : 1;
    localparam logic [31:0] TAPS       = 32'h8020_0003;
    localparam logic [31:0] SEED_FIX   = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [28:0] ALIGN_MASK = ~(29'(NBEATS * 4) - 29'd1);
    localparam logic [31:0] PROB_MASK  = (PROB_BITS == 0) ? 32'd0
                                       : ((32'd1 << PROB_BITS) - 32'd1);
    localparam int          WW         = $clog2(TIMEOUT + 2);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);
    localparam logic [7:0]  LAST_K     = 8'(NBEATS - 1);
    localparam logic [7:0]  ID8        = 8'(ID);
    localparam logic [15:0] NTRANS_C   = 16'(NTRANS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_READ,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [31:0]   lfsr_q;
    logic [31:0]   lfsr_d;
    logic [31:0]   base_q;
    logic [31:0]   base_d;
    logic [15:0]   pat_q;
    logic [7:0]    k_q;
    logic [7:0]    k_inc;
    logic [WW-1:0] wait_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [2:0]    cti_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic          cyc_q;
    logic          done_q;
    logic [15:0]   trans_q;
    logic [15:0]   err_q;
    logic          timeout_q;

    logic [2:0]    slave_d;
    logic          issue;
    logic          ack;
    logic          spurious;
    logic          mismatch;
    logic          expire;
    logic          err_inc;
    logic          last_beat;

    function automatic logic [31:0] beat_data(input logic [15:0] pat, input logic [7:0] k);
        return {pat, ID8, k};
    endfunction

    function automatic logic [2:0] beat_cti(input logic [7:0] k);
        if (!BURST_SEL)
            return 3'b000;
        return (k == LAST_K) ? 3'b111 : 3'b010;
    endfunction

    always_comb begin
        lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        slave_d   = 3'(lfsr_q % 32'(NSLAVES));
        base_d    = {slave_d, lfsr_q[28:0] & ALIGN_MASK};
        issue     = enable_i && !done_q && ((lfsr_q & PROB_MASK) == 32'd0);
        ack       = wb.m_ack_i;
        k_inc     = k_q + 8'd1;
        last_beat = (k_q == LAST_K);
        spurious  = ack && !cyc_q;
        mismatch  = (state_q == S_READ) && cyc_q && ack
                    && (wb.m_dat_i != beat_data(pat_q, k_q));
        // Ack on the expiry cycle takes priority over the timeout.
        expire    = cyc_q && !ack && (wait_q == WAIT_MAX);
        err_inc   = spurious || mismatch || expire;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_FIX;
            base_q    <= 32'd0;
            pat_q     <= 16'd0;
            k_q       <= 8'd0;
            wait_q    <= '0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            cti_q     <= 3'b000;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            cyc_q     <= 1'b0;
            done_q    <= 1'b0;
            trans_q   <= 16'd0;
            err_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;

            if (err_inc && (err_q != 16'hffff))
                err_q <= err_q + 16'd1;

            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        base_q  <= base_d;
                        pat_q   <= lfsr_q[15:0];
                        k_q     <= 8'd0;
                        wait_q  <= '0;
                        adr_q   <= base_d;
                        dat_q   <= beat_data(lfsr_q[15:0], 8'd0);
                        cti_q   <= beat_cti(8'd0);
                        we_q    <= 1'b1;
                        sel_q   <= 4'hf;
                        cyc_q   <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end

                S_WRITE, S_READ: begin
                    if (ack) begin
                        wait_q <= '0;
                        if (last_beat) begin
                            cyc_q <= 1'b0;
                            sel_q <= 4'h0;
                            we_q  <= 1'b0;
                            cti_q <= 3'b000;
                            k_q   <= 8'd0;
                            adr_q <= base_q;
                            dat_q <= beat_data(pat_q, 8'd0);
                            if (state_q == S_WRITE) begin
                                state_q <= S_GAP;
                            end else begin
                                if (trans_q != 16'hffff)
                                    trans_q <= trans_q + 16'd1;
                                if ((trans_q + 16'd1) >= NTRANS_C) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end
                        end else begin
                            k_q   <= k_inc;
                            adr_q <= base_q + {22'd0, k_inc, 2'b00};
                            dat_q <= beat_data(pat_q, k_inc);
                            cti_q <= beat_cti(k_inc);
                        end
                    end else if (expire) begin
                        cyc_q     <= 1'b0;
                        sel_q     <= 4'h0;
                        we_q      <= 1'b0;
                        cti_q     <= 3'b000;
                        k_q       <= 8'd0;
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end

                // One idle bus cycle separates the write phase from the readback.
                S_GAP: begin
                    cyc_q   <= 1'b1;
                    sel_q   <= 4'hf;
                    we_q    <= 1'b0;
                    cti_q   <= beat_cti(8'd0);
                    k_q     <= 8'd0;
                    wait_q  <= '0;
                    state_q <= S_READ;
                end

                S_DONE: begin
                    state_q <= S_DONE;
                end

                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    sel_q   <= 4'h0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign wb.m_adr_o    = adr_q;
    assign wb.m_dat_o    = dat_q;
    assign wb.m_cti_o    = cti_q;
    assign wb.m_we_o     = we_q;
    assign wb.m_sel_o    = sel_q;
    assign wb.m_cyc_o    = cyc_q;
    assign wb.m_stb_o    = cyc_q;
    assign done_o        = done_q;
    assign trans_count_o = trans_q;
    assign err_count_o   = err_q;
    assign timeout_o     = timeout_q;

endmodule
